// File: rtl/haz_if.sv
// haz_if: issue-slot, branch-resolution and resolver-feedback signals plus the
// hazard condition outputs exchanged with haz_detect_unit.
interface haz_if #(
    parameter int REG_AW = 5
);
    logic              iss_valid;
    logic [REG_AW-1:0] iss_rs1;
    logic [REG_AW-1:0] iss_rs2;
    logic [REG_AW-1:0] iss_rd;
    logic              iss_wr;
    logic              iss_load;
    logic              iss_md;
    logic              iss_ctl;
    logic              br_res_valid;
    logic              br_taken;
    logic              br_pred;
    logic              pc_freeze;
    logic              do_flush;
    logic              data;
    logic              fwrd;
    logic              str;
    logic              ctrl;
    logic              branch;
    logic              crct;
    logic              md_busy;
    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr, iss_load, iss_md, iss_ctl,
        output br_res_valid, br_taken, br_pred, pc_freeze, do_flush,
        input  data, fwrd, str, ctrl, branch, crct, md_busy
    );
    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr, iss_load, iss_md, iss_ctl,
        input  br_res_valid, br_taken, br_pred, pc_freeze, do_flush,
        output data, fwrd, str, ctrl, branch, crct, md_busy
    );
endinterface

// File: rtl/haz_detect_unit.sv
// haz_detect_unit: tracks in-flight writers, mul/div occupancy and pending
// branches, and produces the hazard resolver's condition inputs.
module haz_detect_unit #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
) (
    input logic  clk,
    input logic  rst,
    haz_if.slave h
);
    localparam int CW = $clog2(MD_LAT) + 1;
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
    } slot_t;
    slot_t [2:0]   sh_q, sh_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          br_pend_q, br_pend_d;
    logic          acc, hit, load_use, m;
    assign acc = h.iss_valid & ~h.pc_freeze & ~h.do_flush;
    // slot 0 is EX, 1 is MEM, 2 is WB; a flush only ever blocks entry into EX
    always_comb begin
        sh_d      = {sh_q[1], sh_q[0], acc ? slot_t'{1'b1, h.iss_rd, h.iss_wr, h.iss_load} : slot_t'('0)};
        md_cnt_d  = (acc & h.iss_md) ? CW'(MD_LAT - 1) : md_cnt_q - CW'(md_cnt_q != '0);
        br_pend_d = (acc & h.iss_ctl) | (br_pend_q & ~h.br_res_valid);
    end
    always_comb begin
        hit      = 1'b0;
        load_use = 1'b0;
        m        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m        = sh_q[i].v & sh_q[i].wr & (sh_q[i].rd != '0) &
                       ((sh_q[i].rd == h.iss_rs1) | (sh_q[i].rd == h.iss_rs2));
            hit      = hit | m;
            load_use = load_use | (m & (i == 0) & sh_q[i].load);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q      <= '0;
            md_cnt_q  <= '0;
            br_pend_q <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            md_cnt_q  <= md_cnt_d;
            br_pend_q <= br_pend_d;
        end
    end
    assign h.data    = h.iss_valid & hit;
    assign h.fwrd    = h.data & ~load_use;
    assign h.md_busy = md_cnt_q != '0;
    assign h.str     = h.iss_valid & h.iss_md & h.md_busy;
    assign h.ctrl    = br_pend_q | (h.iss_valid & h.iss_ctl);
    assign h.branch  = h.br_res_valid;
    assign h.crct    = h.br_res_valid & (h.br_taken == h.br_pred);
endmodule

// File: tb/tb_haz_detect_unit.sv
// tb_haz_detect_unit: directed vector table plus randomized traffic checked
// against an issue-history reference model.
module tb_haz_detect_unit;
    localparam int MD_LAT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    haz_if #(.REG_AW(5)) h ();
    haz_detect_unit #(.REG_AW(5), .MD_LAT(MD_LAT)) dut (.clk(clk), .rst(rst), .h(h));

    typedef struct {
        logic       rst, v;
        logic [4:0] rs1, rs2, rd;
        logic       wr, ld, md, ctl, res, tk, pr, frz, fl;
        logic [6:0] e;
    } vec_t;
    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       wr, ld;
    } rec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_md = -100;
    int   last_br = -1;
    int   last_res = -1;
    rec_t hist[$];
    rec_t bub = '{1'b0, 5'd0, 1'b0, 1'b0};
    vec_t tbl[$];

    function automatic vec_t mk(int rs, int v, int rs1, int rs2, int rd, int wr, int ld, int md,
                                int ctl, int res, int tk, int pr, int frz, int fl, logic [6:0] e);
        vec_t r;
        r.rst = rs[0]; r.v = v[0]; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
        r.wr = wr[0]; r.ld = ld[0]; r.md = md[0]; r.ctl = ctl[0]; r.res = res[0];
        r.tk = tk[0]; r.pr = pr[0]; r.frz = frz[0]; r.fl = fl[0]; r.e = e;
        return r;
    endfunction

    // expected {data,fwrd,str,ctrl,branch,crct,md_busy} from issue history
    function automatic logic [6:0] model(vec_t t);
        logic hit = 1'b0, lu = 1'b0, m, busy, pend, data;
        for (int i = 0; i < 3; i++) begin
            m = hist[i].v && hist[i].wr && hist[i].rd != 0 && (hist[i].rd == t.rs1 || hist[i].rd == t.rs2);
            hit = hit | m;
            if (m && i == 0 && hist[i].ld) lu = 1'b1;
        end
        data = t.v && hit;
        busy = (cyc - last_md) >= 1 && (cyc - last_md) <= MD_LAT - 1;
        pend = last_br >= 0 && last_br >= last_res;
        return {data, data && !lu, t.v && t.md && busy, pend || (t.v && t.ctl),
                t.res, t.res && (t.tk == t.pr), busy};
    endfunction

    function automatic void model_update(vec_t t);
        logic acc = t.v && !t.frz && !t.fl;
        if (t.rst) begin
            hist = '{bub, bub, bub};
            last_md = -100; last_br = -1; last_res = -1;
        end else begin
            hist.push_front(acc ? rec_t'{1'b1, t.rd, t.wr, t.ld} : bub);
            void'(hist.pop_back());
            if (acc && t.md) last_md = cyc;
            if (acc && t.ctl) last_br = cyc;
            if (t.res) last_res = cyc;
        end
        cyc++;
    endfunction

    task automatic step(vec_t t, bit use_tbl, string nm);
        logic [6:0] act, exp;
        rst = t.rst; h.iss_valid = t.v; h.iss_rs1 = t.rs1; h.iss_rs2 = t.rs2; h.iss_rd = t.rd;
        h.iss_wr = t.wr; h.iss_load = t.ld; h.iss_md = t.md; h.iss_ctl = t.ctl;
        h.br_res_valid = t.res; h.br_taken = t.tk; h.br_pred = t.pr;
        h.pc_freeze = t.frz; h.do_flush = t.fl;
        #1;
        act = {h.data, h.fwrd, h.str, h.ctrl, h.branch, h.crct, h.md_busy};
        exp = use_tbl ? t.e : model(t);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d {data,fwrd,str,ctrl,branch,crct,md_busy} got %b expected %b",
                     nm, cyc, act, exp);
        end
        @(posedge clk);
        model_update(t);
        #1;
    endtask

    initial begin
        hist = '{bub, bub, bub};
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0), 1'b0, "init");
        n_chk = 0; n_fail = 0;
        // reset state, load-use, plain RAW, rd=0, branch, flush, set-wins
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
        tbl.push_back(mk(0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1000000));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100000));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1100000));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000000));
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
        tbl.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 7'b0001000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 7'b0001100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
        tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0000000));
        tbl.push_back(mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 7'b0001110));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'b0001110));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
        foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl[%0d]", i));
        // mul/div occupancy: accept, then re-present under freeze
        step(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7'b0000000), 1'b1, "md_t0");
        for (int k = 1; k <= 3; k++)
            step(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 7'b0010001), 1'b1, $sformatf("md_t%0d", k));
        step(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 7'b0000000), 1'b1, "md_t4");
        // mid-operation reset with full slots, busy mul/div and pending branch
        step(mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 7'b0001000), 1'b1, "rst_fill0");
        step(mk(0, 1, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 7'b0001000), 1'b1, "rst_fill1");
        step(mk(0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001001), 1'b1, "rst_fill2");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001001), 1'b1, "rst_assert");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000), 1'b1, "rst_idle");
        step(mk(0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7'b0000000), 1'b1, "rst_cleared");
        for (int n = 0; n < 400; n++) begin
            vec_t t;
            t.rst = $urandom_range(0, 49) == 0;
            t.v = $urandom_range(0, 3) != 0;
            t.rs1 = 5'($urandom_range(0, 7)); t.rs2 = 5'($urandom_range(0, 7)); t.rd = 5'($urandom_range(0, 7));
            t.wr = $urandom_range(0, 3) != 0; t.ld = $urandom_range(0, 2) == 0;
            t.md = $urandom_range(0, 5) == 0; t.ctl = $urandom_range(0, 5) == 0;
            t.res = $urandom_range(0, 3) == 0; t.tk = 1'($urandom_range(0, 1)); t.pr = 1'($urandom_range(0, 1));
            t.frz = $urandom_range(0, 3) == 0; t.fl = $urandom_range(0, 7) == 0;
            t.e = '0;
            step(t, 1'b0, $sformatf("rand[%0d]", n));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
